// File: rtl/pos_sweep_pkg.sv
// Shared types and sizing for the PoS truth-table sweep controller.
package pos_sweep_pkg;

   localparam int N_IN = 4;           // function inputs a,b,c,d
   localparam int TT_W = 1 << N_IN;   // minterm count
   localparam int ERRW = 5;           // holds 0..TT_W mismatches

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/pos_sweep_ctrl_settle_timer.sv
// Settle timer: loadable down-counter with a zero flag. Loading presets
// SETTLE_CYCLES-1, so a load followed by decrements to zero spans exactly
// SETTLE_CYCLES cycles of the consumer's SETTLE state.
module settle_timer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CW            = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // load has priority; decrement stops at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (load)
         cnt_q <= RELOAD;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pos_sweep_ctrl.sv
// Sweeps a 4-input PoS block through all minterms, samples s after a
// programmable settle time, and builds observed/mismatch tables plus an
// error count and pass flag against a latched expected mask.
module pos_sweep_ctrl
   import pos_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [TT_W-1:0]   expected,
   output logic [N_IN-1:0]   abcd_out,
   input  logic              s_in,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [TT_W-1:0]   truth,
   output logic [TT_W-1:0]   mismatch,
   output logic [ERRW-1:0]   err_count,
   output logic              pass
);

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q;
   logic [TT_W-1:0]   exp_q;
   logic [TT_W-1:0]   truth_q;
   logic [TT_W-1:0]   mis_q;
   logic [ERRW-1:0]   err_q;
   logic              pass_q;
   logic              aborted_q;

   logic              acc_start;
   logic              do_sample;
   logic              do_abort;
   logic              tmr_load;
   logic              tmr_dec;
   logic              tmr_zero;
   logic              last;
   logic              mis_bit;
   logic [ERRW-1:0]   err_next;

   assign last     = &idx_q;
   assign mis_bit  = s_in ^ exp_q[idx_q];
   assign err_next = err_q + {{(ERRW-1){1'b0}}, mis_bit};

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .dec   (tmr_dec),
      .zero  (tmr_zero)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // next-state and sweep control; abort outranks sampling so an aborted
   // SAMPLE neither records its minterm nor reaches DONE
   always_comb begin
      state_d   = state_q;
      acc_start = 1'b0;
      do_sample = 1'b0;
      do_abort  = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_start = 1'b1;
               tmr_load  = 1'b1;
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               do_abort = 1'b1;
               state_d  = IDLE;
            end else if (tmr_zero) begin
               state_d  = SAMPLE;
            end else begin
               tmr_dec  = 1'b1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               do_abort = 1'b1;
               state_d  = IDLE;
            end else begin
               do_sample = 1'b1;
               if (last) begin
                  state_d  = DONE;
               end else begin
                  tmr_load = 1'b1;
                  state_d  = SETTLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // result registers; they hold between sweeps and clear only on a new start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         exp_q     <= '0;
         truth_q   <= '0;
         mis_q     <= '0;
         err_q     <= '0;
         pass_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= do_abort;
         if (acc_start) begin
            idx_q   <= '0;
            exp_q   <= expected;
            truth_q <= '0;
            mis_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
         end
         if (do_sample) begin
            truth_q[idx_q] <= s_in;
            mis_q[idx_q]   <= mis_bit;
            err_q          <= err_next;
            // pass is settled on entry to DONE so it is valid alongside done
            if (last)
               pass_q <= (err_next == '0);
            else
               idx_q  <= idx_q + 1'b1;
         end
         if (do_abort)
            pass_q <= 1'b0;
      end
   end

   assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done      = (state_q == DONE);
   assign aborted   = aborted_q;
   // index is only presented while sweeping; otherwise the PoS sees m0
   assign abcd_out  = busy ? idx_q : '0;
   assign truth     = truth_q;
   assign mismatch  = mis_q;
   assign err_count = err_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// Bench for pos_sweep_ctrl: two instances (settle 1 and settle 3) each
// driving a table model of the PoS function; completion/abort events are
// checked against a queue of hand-computed expected results.
module tb_pos_sweep_ctrl;

   localparam logic [15:0] POS_TT = 16'hD0C4;

   typedef struct {
      logic        is_abort;
      logic [15:0] truth;
      logic [15:0] mis;
      logic [4:0]  err;
      logic        pass;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   logic        start_a, abort_a, s_in_a, busy_a, done_a, aborted_a, pass_a;
   logic [15:0] expected_a, truth_a, mis_a;
   logic [3:0]  abcd_a;
   logic [4:0]  err_a;

   logic        start_b, abort_b, s_in_b, busy_b, done_b, aborted_b, pass_b;
   logic [15:0] expected_b, truth_b, mis_b;
   logic [3:0]  abcd_b;
   logic [4:0]  err_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign s_in_a = POS_TT[abcd_a];
   assign s_in_b = POS_TT[abcd_b];

   pos_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .expected(expected_a), .abcd_out(abcd_a), .s_in(s_in_a),
      .busy(busy_a), .done(done_a), .aborted(aborted_a), .truth(truth_a),
      .mismatch(mis_a), .err_count(err_a), .pass(pass_a));

   pos_sweep_ctrl #(.SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .expected(expected_b), .abcd_out(abcd_b), .s_in(s_in_b),
      .busy(busy_b), .done(done_b), .aborted(aborted_b), .truth(truth_b),
      .mismatch(mis_b), .err_count(err_b), .pass(pass_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cmp_ev(input string tag, input exp_t e, input logic dn, input logic ab,
                         input logic [15:0] t, input logic [15:0] m,
                         input logic [4:0] er, input logic p);
      chk({tag, "_cycle"},    cyc, e.cyc);
      chk({tag, "_done"},     dn, !e.is_abort);
      chk({tag, "_aborted"},  ab, e.is_abort);
      chk({tag, "_truth"},    t, e.truth);
      chk({tag, "_mismatch"}, m, e.mis);
      chk({tag, "_err"},      er, e.err);
      chk({tag, "_pass"},     p, e.pass);
   endtask

   // monitor A: every done/aborted pulse must match the head of its queue
   always @(negedge clk) begin
      exp_t e;
      if (done_a || aborted_a) begin
         if (qa.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL a_unexpected_event: done=%0b aborted=%0b cyc %0d, none expected",
                     done_a, aborted_a, cyc);
         end else begin
            e = qa.pop_front();
            cmp_ev("a", e, done_a, aborted_a, truth_a, mis_a, err_a, pass_a);
         end
      end
   end

   // monitor B
   always @(negedge clk) begin
      exp_t e;
      if (done_b || aborted_b) begin
         if (qb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL b_unexpected_event: done=%0b aborted=%0b cyc %0d, none expected",
                     done_b, aborted_b, cyc);
         end else begin
            e = qb.pop_front();
            cmp_ev("b", e, done_b, aborted_b, truth_b, mis_b, err_b, pass_b);
         end
      end
   end

   task automatic push_a(input logic ab, input logic [15:0] t, input logic [15:0] m,
                         input logic [4:0] er, input logic p, input int c);
      exp_t e;
      e.is_abort = ab; e.truth = t; e.mis = m; e.err = er; e.pass = p; e.cyc = c;
      qa.push_back(e);
   endtask

   task automatic push_b(input logic ab, input logic [15:0] t, input logic [15:0] m,
                         input logic [4:0] er, input logic p, input int c);
      exp_t e;
      e.is_abort = ab; e.truth = t; e.mis = m; e.err = er; e.pass = p; e.cyc = c;
      qb.push_back(e);
   endtask

   // one-cycle start pulse from the current negedge; expected is scrambled
   // afterwards so a design that fails to latch it shows up
   task automatic go_a(input logic [15:0] e);
      expected_a = e; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; expected_a = ~e;
   endtask

   task automatic go_b(input logic [15:0] e);
      expected_b = e; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0; expected_b = ~e;
   endtask

   task automatic drain_a(input string name);
      int n = 0;
      while (qa.size() != 0 && n < 300) begin @(negedge clk); n++; end
      chk(name, qa.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic drain_b(input string name);
      int n = 0;
      while (qb.size() != 0 && n < 300) begin @(negedge clk); n++; end
      chk(name, qb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_abcd"},    abcd_a, 0);
      chk({tag, "_busy"},    busy_a, 0);
      chk({tag, "_done"},    done_a, 0);
      chk({tag, "_aborted"}, aborted_a, 0);
      chk({tag, "_truth"},   truth_a, 0);
      chk({tag, "_mis"},     mis_a, 0);
      chk({tag, "_err"},     err_a, 0);
      chk({tag, "_pass"},    pass_a, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; expected_a = '0;
      start_b = 1'b0; abort_b = 1'b0; expected_b = '0;
      repeat (3) @(negedge clk);
      chk_zero_a("rst_a");
      chk("rst_b_abcd", abcd_b, 0);
      chk("rst_b_busy", busy_b, 0);
      chk("rst_b_pass", pass_b, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // matching sweep; a second start mid-sweep must be ignored
      c0 = cyc;
      push_a(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 33);
      go_a(16'hD0C4);
      repeat (10) @(negedge clk);
      chk("t1_busy_mid", busy_a, 1);
      expected_a = 16'hFFFF; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      drain_a("t1_drain");

      // all-ones mask; start and abort together in IDLE, start wins
      c0 = cyc;
      push_a(1'b0, 16'hD0C4, 16'h2F3B, 5'd10, 1'b0, c0 + 33);
      abort_a = 1'b1;
      go_a(16'hFFFF);
      abort_a = 1'b0;
      drain_a("t2_drain");
      // abort in IDLE does nothing; results hold
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      repeat (2) @(negedge clk);
      chk("t2_hold_truth", truth_a, 16'hD0C4);
      chk("t2_hold_mis",   mis_a, 16'h2F3B);
      chk("t2_hold_err",   err_a, 10);
      chk("t2_hold_abcd",  abcd_a, 0);
      chk("t2_qa_empty",   qa.size(), 0);

      // settle 3: each minterm held 4 cycles, busy throughout, done at 64
      c0 = cyc;
      push_b(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 65);
      go_b(16'hD0C4);
      for (int k = 0; k < 64; k++) begin
         chk($sformatf("t3_abcd_%0d", k), abcd_b, k >> 2);
         chk($sformatf("t3_busy_%0d", k), busy_b, 1);
         @(negedge clk);
      end
      chk("t3_busy_done", busy_b, 0);
      drain_b("t3_drain");

      // abort during SAMPLE of m5
      c0 = cyc;
      go_a(16'hD0C4);
      repeat (11) @(negedge clk);
      chk("t4_abcd_m5", abcd_a, 5);
      push_a(1'b1, 16'h0004, 16'h0000, 5'd0, 1'b0, c0 + 13);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      drain_a("t4_drain");
      chk("t4_busy", busy_a, 0);
      chk("t4_abcd", abcd_a, 0);

      // abort during SAMPLE of m15 beats the DONE transition
      c0 = cyc;
      go_a(16'hFFFF);
      repeat (31) @(negedge clk);
      chk("t4b_abcd_m15", abcd_a, 15);
      push_a(1'b1, 16'h50C4, 16'h2F3B, 5'd10, 1'b0, c0 + 33);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      drain_a("t4b_drain");

      // start held high: next sweep accepted only from the IDLE after DONE
      c0 = cyc;
      push_a(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 33);
      push_a(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 67);
      expected_a = 16'hD0C4; start_a = 1'b1;
      repeat (34) @(negedge clk);
      chk("t5_gap_busy", busy_a, 0);
      chk("t5_gap_abcd", abcd_a, 0);
      repeat (33) @(negedge clk);
      start_a = 1'b0;
      drain_a("t5_drain");

      // async reset mid-SETTLE of m9
      c0 = cyc;
      push_a(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 33);
      go_a(16'hD0C4);
      repeat (18) @(negedge clk);
      chk("t6_abcd_m9", abcd_a, 9);
      chk("t6_busy_m9", busy_a, 1);
      #1 rst_n = 1'b0;
      qa.delete();
      #1 chk_zero_a("t6_rst_now");
      repeat (2) @(negedge clk);
      chk_zero_a("t6_rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      c0 = cyc;
      push_a(1'b0, 16'hD0C4, 16'h0000, 5'd0, 1'b1, c0 + 33);
      go_a(16'hD0C4);
      drain_a("t6_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
